key_event_queue: RTL and testbench



---
 rtl/key_event_queue_pkg.sv | 21 ++
 rtl/key_event_queue_if.sv | 28 ++
 rtl/key_event_queue_fifo.sv | 79 +++++++
 rtl/key_event_queue.sv | 91 +++++++++
 tb/tb_key_event_queue.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/key_event_queue_pkg.sv
// Shared constants for the key event queue: rd_data field layout and a
// ceil-log2 helper used to size pointers and key indices.
package key_event_pkg;

    localparam int NONEMPTY_BIT = 31;
    localparam int OVF_BIT      = 30;
    localparam int COUNT_LSB    = 16;
    localparam int COUNT_W      = 8;
    localparam int KEY_LSB      = 0;
    localparam int KEY_W        = 16;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/key_event_queue_if.sv
// Bus between the debounce/MMIO side (master) and the key event queue (slave).
interface key_event_queue_if #(
    parameter int NUM_KEYS = 4
);

    logic [NUM_KEYS-1:0] key_pulse;
    logic                rd_en;
    logic                clr_ovf;
    logic [31:0]         rd_data;
    logic                irq;

    modport master (
        output key_pulse,
        output rd_en,
        output clr_ovf,
        input  rd_data,
        input  irq
    );

    modport slave (
        input  key_pulse,
        input  rd_en,
        input  clr_ovf,
        output rd_data,
        output irq
    );

endinterface

// File: rtl/key_event_queue_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO is accepted when a
// pop happens in the same cycle.
module sync_fifo
    import key_event_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             push_acc_o,
    output logic             empty_o,
    output logic [clog2(DEPTH):0] count_o
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtrQ, wrPtrD;
    logic [PTR_W-1:0] rdPtrQ, rdPtrD;
    logic [CNT_W-1:0] countQ, countD;
    logic             full;
    logic             empty;
    logic             doPush;
    logic             doPop;

    assign full  = (countQ == CNT_W'(DEPTH));
    assign empty = (countQ == '0);

    // Pop on empty is ignored; a pop frees the slot the simultaneous push needs.
    assign doPop  = pop_i & ~empty;
    assign doPush = push_i & (~full | doPop);

    always_comb begin
        wrPtrD = wrPtrQ;
        rdPtrD = rdPtrQ;
        countD = countQ;
        if (doPush) begin
            wrPtrD = wrPtrQ + PTR_W'(1);
        end
        if (doPop) begin
            rdPtrD = rdPtrQ + PTR_W'(1);
        end
        if (doPush && !doPop) begin
            countD = countQ + CNT_W'(1);
        end else if (doPop && !doPush) begin
            countD = countQ - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrPtrQ <= '0;
            rdPtrQ <= '0;
            countQ <= '0;
        end else begin
            wrPtrQ <= wrPtrD;
            rdPtrQ <= rdPtrD;
            countQ <= countD;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtrQ] <= wdata_i;
        end
    end

    assign rdata_o    = empty ? '0 : mem[rdPtrQ];
    assign push_acc_o = doPush;
    assign empty_o    = empty;
    assign count_o    = countQ;

endmodule

// File: rtl/key_event_queue.sv
// Collects debounced key press pulses, arbitrates them lowest-index first and
// queues their indices for software, flagging lost events with a sticky bit.
module key_event_queue
    import key_event_pkg::*;
#(
    parameter int NUM_KEYS = 4,
    parameter int DEPTH    = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    key_event_queue_if.slave bus
);

    localparam int KEY_IDX_W = (NUM_KEYS > 1) ? clog2(NUM_KEYS) : 1;
    localparam int CNT_W     = clog2(DEPTH) + 1;

    logic [NUM_KEYS-1:0]  pendQ, pendD;
    logic                 ovfQ, ovfD;
    logic [NUM_KEYS-1:0]  grant;
    logic [KEY_IDX_W-1:0] grantIdx;
    logic                 grantValid;
    logic                 lostPulse;
    logic                 droppedPush;
    logic                 pushAcc;
    logic                 fifoEmpty;
    logic [KEY_IDX_W-1:0] headIdx;
    logic [CNT_W-1:0]     fifoCount;

    always_comb begin
        grant      = '0;
        grantIdx   = '0;
        grantValid = 1'b0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (pendQ[i] && !grantValid) begin
                grant[i]   = 1'b1;
                grantIdx   = KEY_IDX_W'(i);
                grantValid = 1'b1;
            end
        end
    end

    // A pulse on a key that is already waiting merges into it and counts as lost.
    assign lostPulse   = |(bus.key_pulse & pendQ & ~grant);
    assign droppedPush = grantValid & ~pushAcc;
    assign pendD       = (pendQ & ~grant) | bus.key_pulse;

    always_comb begin
        ovfD = ovfQ;
        if (lostPulse || droppedPush) begin
            ovfD = 1'b1;
        end else if (bus.clr_ovf) begin
            ovfD = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pendQ <= '0;
            ovfQ  <= 1'b0;
        end else begin
            pendQ <= pendD;
            ovfQ  <= ovfD;
        end
    end

    sync_fifo #(
        .WIDTH (KEY_IDX_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (grantValid),
        .wdata_i    (grantIdx),
        .pop_i      (bus.rd_en),
        .rdata_o    (headIdx),
        .push_acc_o (pushAcc),
        .empty_o    (fifoEmpty),
        .count_o    (fifoCount)
    );

    always_comb begin
        bus.rd_data                         = '0;
        bus.rd_data[NONEMPTY_BIT]           = ~fifoEmpty;
        bus.rd_data[OVF_BIT]                = ovfQ;
        bus.rd_data[COUNT_LSB +: COUNT_W]   = COUNT_W'(fifoCount);
        bus.rd_data[KEY_LSB +: KEY_W]       = KEY_W'(headIdx);
    end

    assign bus.irq = ~fifoEmpty | ovfQ;

endmodule

// File: tb/tb_key_event_queue.sv
// Directed self-checking bench for key_event_queue (NUM_KEYS=4, DEPTH=8).
module tb_key_event_queue;

    logic clk;
    logic rst_n;
    int   vectorsApplied;
    int   miscompares;

    key_event_queue_if #(.NUM_KEYS(4)) bus ();

    key_event_queue #(
        .NUM_KEYS (4),
        .DEPTH    (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, then return just after the edge that consumed them.
    task automatic applyStimulus(input logic [3:0] pulse, input logic rd, input logic clr);
        bus.key_pulse = pulse;
        bus.rd_en     = rd;
        bus.clr_ovf   = clr;
        @(posedge clk);
        #1;
        bus.key_pulse = '0;
        bus.rd_en     = 1'b0;
        bus.clr_ovf   = 1'b0;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            applyStimulus(4'b0000, 1'b0, 1'b0);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorsApplied++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    initial begin
        vectorsApplied = 0;
        miscompares    = 0;
        bus.key_pulse  = '0;
        bus.rd_en      = 1'b0;
        bus.clr_ovf    = 1'b0;
        rst_n          = 1'b0;
        idle(2);
        checkOutput("reset_rd_data", bus.rd_data, 32'h0000_0000);
        checkOutput("reset_irq", 32'(bus.irq), 32'd0);
        rst_n = 1'b1;
        idle(8);

        $display("[TB] single pulse on key 2");
        applyStimulus(4'b0100, 1'b0, 1'b0);
        checkOutput("k2_pending_only", bus.rd_data, 32'h0000_0000);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        checkOutput("k2_visible", bus.rd_data, 32'h8001_0002);
        checkOutput("k2_irq", 32'(bus.irq), 32'd1);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("k2_popped", bus.rd_data, 32'h0000_0000);
        checkOutput("k2_irq_low", 32'(bus.irq), 32'd0);

        $display("[TB] simultaneous pulses 1011");
        applyStimulus(4'b1011, 1'b0, 1'b0);
        checkOutput("multi_n", bus.rd_data, 32'h0000_0000);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        checkOutput("multi_n1", bus.rd_data, 32'h8001_0000);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        checkOutput("multi_n2", bus.rd_data, 32'h8002_0000);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        checkOutput("multi_n3", bus.rd_data, 32'h8003_0000);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("multi_pop0", bus.rd_data, 32'h8002_0001);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("multi_pop1", bus.rd_data, 32'h8001_0003);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("multi_pop3", bus.rd_data, 32'h0000_0000);

        $display("[TB] overflow by filling the queue");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(4'b0010, 1'b0, 1'b0);
            idle(2);
        end
        checkOutput("full_ovf", bus.rd_data, 32'hC008_0001);
        applyStimulus(4'b0000, 1'b0, 1'b1);
        checkOutput("ovf_cleared", bus.rd_data, 32'h8008_0001);
        checkOutput("full_irq", 32'(bus.irq), 32'd1);

        $display("[TB] push and pop together while full");
        applyStimulus(4'b1000, 1'b0, 1'b0);
        checkOutput("full_k3_pending", bus.rd_data, 32'h8008_0001);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("full_push_pop", bus.rd_data, 32'h8008_0001);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(4'b0000, 1'b1, 1'b0);
        end
        checkOutput("tail_is_k3", bus.rd_data, 32'h8001_0003);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("drained", bus.rd_data, 32'h0000_0000);

        $display("[TB] lost pulse on a waiting key");
        applyStimulus(4'b0111, 1'b0, 1'b0);
        applyStimulus(4'b0100, 1'b0, 1'b0);
        checkOutput("lost_ovf", bus.rd_data, 32'hC001_0000);
        idle(2);
        checkOutput("lost_count", bus.rd_data, 32'hC003_0000);
        idle(2);
        checkOutput("lost_no_dup", bus.rd_data, 32'hC003_0000);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("lost_pop0", bus.rd_data, 32'hC002_0001);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("lost_pop1", bus.rd_data, 32'hC001_0002);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("lost_pop2", bus.rd_data, 32'h4000_0000);
        checkOutput("ovf_irq", 32'(bus.irq), 32'd1);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("pop_empty", bus.rd_data, 32'h4000_0000);
        applyStimulus(4'b0000, 1'b0, 1'b1);
        checkOutput("clr_only", bus.rd_data, 32'h0000_0000);
        checkOutput("clr_irq", 32'(bus.irq), 32'd0);

        $display("[TB] reset with entries queued and pending");
        applyStimulus(4'b1111, 1'b0, 1'b0);
        idle(4);
        checkOutput("pre_rst_4", bus.rd_data, 32'h8004_0000);
        applyStimulus(4'b0001, 1'b0, 1'b0);
        idle(1);
        applyStimulus(4'b0110, 1'b0, 1'b0);
        checkOutput("pre_rst_5", bus.rd_data, 32'h8005_0000);
        rst_n = 1'b0;
        applyStimulus(4'b0000, 1'b0, 1'b0);
        checkOutput("mid_rst", bus.rd_data, 32'h0000_0000);
        checkOutput("mid_rst_irq", 32'(bus.irq), 32'd0);
        rst_n = 1'b1;
        idle(3);
        checkOutput("post_rst_idle", bus.rd_data, 32'h0000_0000);
        applyStimulus(4'b1000, 1'b0, 1'b0);
        checkOutput("post_rst_n", bus.rd_data, 32'h0000_0000);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        checkOutput("post_rst_k3", bus.rd_data, 32'h8001_0003);

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
